axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- AXI4-Lite initiator that issues single read/write transactions from a simple command/response interface.
- Drives the accelerator's AXI-Lite register slave (run/set/mode/finish/LED registers) from a local sequencer or testbench-side controller, replacing the PS in standalone and bring-up builds.
- One outstanding transaction at a time; no bursts, no pipelining.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data bus width (multiple of 8).
- C_M_AXI_ADDR_WIDTH, 4, address bus width.

Ports:
- clk  in  1  single clock for all logic and the AXI bus.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  target address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  one-cycle pulse; response fields are valid.
- rsp_write  out  1  echoes cmd_write of the completed command.
- rsp_rdata  out  DATA  read data; holds 0 for writes.
- rsp_resp  out  2  BRESP or RRESP captured from the slave.
- busy  out  1  high whenever the state is not IDLE.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY: out ADDR / out 3 / out 1 / in 1.
- M_AXI_WDATA/WSTRB/WVALID/WREADY: out DATA / out DATA/8 / out 1 / in 1.
- M_AXI_BRESP/BVALID/BREADY: in 2 / in 1 / out 1.
- M_AXI_ARADDR/ARPROT/ARVALID/ARREADY: out ADDR / out 3 / out 1 / in 1.
- M_AXI_RDATA/RRESP/RVALID/RREADY: in DATA / in 2 / in 1 / out 1.

Behaviour:
- Reset values:
  - State is IDLE.
  - All *VALID and *READY outputs are 0.
  - rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_resp=0, busy=0.
  - Address, data and strobe registers are 0.
- AWPROT and ARPROT are tied to 3'b000.
- States: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr, wdata, wstrb and write.
  - Next state is WRITE if cmd_write=1, otherwise READ.
- WRITE:
  - AWVALID and WVALID both assert on the first cycle of WRITE.
  - Each VALID deasserts on the edge after its own handshake (VALID && READY).
  - Internal flags aw_done/w_done track the two handshakes independently; AW may complete before W, W before AW, or both together.
  - A VALID never drops before its handshake completes.
  - AWADDR, WDATA and WSTRB are stable while their VALID is high.
  - When both handshakes are done, go to WRESP. If both complete in the same cycle, go to WRESP on the next edge.
- WRESP:
  - BREADY=1.
  - On BVALID: capture BRESP into rsp_resp, clear rsp_rdata, go to RESP.
- READ:
  - ARVALID=1 until ARREADY, then go to RDATA.
- RDATA:
  - RREADY=1.
  - On RVALID: capture RDATA and RRESP, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; cmd_ready=0.
  - Next state is IDLE.
  - rsp_* fields hold their values until the next response.
- Latency with a zero-wait slave:
  - Write: accept at T, AW/W handshake at T+1, B at T+2, rsp_valid at T+3.
  - Read: accept at T, AR at T+1, R at T+2, rsp_valid at T+3.
- Bus response handling:
  - SLVERR and DECERR are passed through on rsp_resp; no retry.
  - BVALID or RVALID arriving outside WRESP/RDATA is ignored, because BREADY and RREADY are 0 there.
- cmd_valid in any state other than IDLE is not accepted; the command stays pending at the requester.
- rst mid-transaction: on the next edge all outputs return to reset values, and any pending transaction is abandoned. The slave must be reset in the same cycle.

Test Plan:
- Write, zero-wait slave: cmd write addr=0x0, wdata=0x00000001, wstrb=0xF.
  - Required: AW/W handshake 1 cycle after accept, rsp_valid 3 cycles after accept.
  - Required: rsp_write=1, rsp_resp=0.
  - Required: slave register 0 reads back 0x1.
- AWREADY/WREADY skew, 4 writes with addr=0x4, wdata=0x00000003:
  - AWREADY 3 cycles before WREADY: required that AWVALID drops after its handshake while WVALID stays high until its own.
  - Reverse order (WREADY first): same independent behaviour.
  - Both ready in the same cycle: both VALIDs drop on the next edge.
  - In all four cases the B handshake happens exactly once.
- Read with RVALID delayed 5 cycles, slave RDATA=0xDEADBEEF, RRESP=0:
  - Required: RREADY high throughout the wait.
  - Required: rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_valid a single-cycle pulse.
- Error passthrough: slave returns BRESP=2'b10 on a write to addr=0xC.
  - Required: rsp_resp=2'b10, then return to IDLE with cmd_ready=1 one cycle after rsp_valid.
- Back-to-back commands, cmd_valid held high:
  - Required: the second command is accepted only after RESP, and no overlap of AW/AR is ever observed.
- Reset mid-operation: assert rst while AWVALID=1 and AWREADY=0.
  - Required: on the next edge all VALID/READY=0, busy=0, rsp_valid=0.
  - Required: a subsequent read command works normally.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master
//
// Purpose:
//   Single-outstanding AXI4-Lite initiator. A local sequencer (or a bring-up
//   controller) hands over one read or write command at a time. The block
//   performs the bus transaction and returns a one-cycle response pulse that
//   carries the slave's BRESP/RRESP and, for reads, the returned data.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   cmd_*               command request (valid/ready handshake, accepted in IDLE only)
//   rsp_*               response (rsp_valid pulses for one cycle, fields hold afterwards)
//   busy                high whenever a transaction is in flight
//   M_AXI_AW*/W*/B*     AXI4-Lite write address, write data and write response channels
//   M_AXI_AR*/R*        AXI4-Lite read address and read data channels
module axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,

  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                              rsp_valid,
  output logic                              rsp_write,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,

  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,

  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,

  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,

  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WRESP,
    S_READ,
    S_RDATA,
    S_RESP
  } state_t;

  state_t                          state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic                            write_q, write_d;
  logic                            aw_done_q, aw_done_d;
  logic                            w_done_q, w_done_d;
  logic                            rsp_write_q, rsp_write_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                      rsp_resp_q, rsp_resp_d;

  logic                            aw_fin;
  logic                            w_fin;

  // The bus-facing address/data/strobe come straight from the latched command,
  // so they cannot move while a VALID is waiting for its READY.
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign busy      = (state_q != S_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      write_q     <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      write_q     <= write_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_d       = write_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;

    cmd_ready     = 1'b0;
    rsp_valid     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    aw_fin        = 1'b0;
    w_fin         = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? S_WRITE : S_READ;
        end
      end

      // AW and W are independent channels: each VALID stays up until its own
      // handshake and then drops, regardless of the other channel's progress.
      S_WRITE: begin
        M_AXI_AWVALID = !aw_done_q;
        M_AXI_WVALID  = !w_done_q;
        aw_fin        = aw_done_q || M_AXI_AWREADY;
        w_fin         = w_done_q  || M_AXI_WREADY;
        aw_done_d     = aw_fin;
        w_done_d      = w_fin;
        if (aw_fin && w_fin) begin
          state_d = S_WRESP;
        end
      end

      S_WRESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          rsp_write_d = write_q;
          rsp_rdata_d = '0;
          rsp_resp_d  = M_AXI_BRESP;
          state_d     = S_RESP;
        end
      end

      S_READ: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          rsp_write_d = write_q;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
          state_d     = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master
//
// Purpose:
//   Directed self-checking bench for axi_lite_master. A small AXI4-Lite slave
//   with per-channel programmable wait states and a 4-entry register file sits
//   on the bus. A passive monitor timestamps every handshake so each test can
//   compare latencies and channel behaviour against hand-computed values.
module tb_axi_lite_master;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [DW-1:0]   cmd_wdata;
  logic [SW-1:0]   cmd_wstrb;
  logic            rsp_valid;
  logic            rsp_write;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;

  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  logic [DW-1:0]   wdata;
  logic [SW-1:0]   wstrb;
  logic            wvalid;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_lite_master #(
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  // Slave configuration, changed by the tests between transactions.
  int          aw_delay = 0;
  int          w_delay  = 0;
  int          b_delay  = 0;
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  bit          rdata_ovr = 1'b0;
  logic [DW-1:0] rdata_cfg = '0;

  // Slave state.
  int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit          s_aw_got, s_w_got, b_busy, bvalid_r, r_busy, rvalid_r;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata;
  logic [SW-1:0] s_wstrb;
  logic [DW-1:0] regs [4];
  logic [DW-1:0] rdata_r;

  logic          aw_hs, w_hs, ar_hs, have_aw, have_w;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_data;
  logic [SW-1:0] cur_strb;

  // READY rises once VALID has waited the programmed number of cycles.
  assign awready  = awvalid && (aw_cnt >= aw_delay);
  assign wready   = wvalid  && (w_cnt  >= w_delay);
  assign arready  = arvalid && (ar_cnt >= ar_delay);
  assign bvalid   = bvalid_r;
  assign bresp    = bresp_cfg;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = rresp_cfg;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign ar_hs    = arvalid && arready;
  assign have_aw  = s_aw_got || aw_hs;
  assign have_w   = s_w_got || w_hs;
  assign cur_addr = aw_hs ? awaddr : s_awaddr;
  assign cur_data = w_hs ? wdata : s_wdata;
  assign cur_strb = w_hs ? wstrb : s_wstrb;

  // Slave model: register write once both AW and W have arrived, then B after
  // b_delay cycles; read data after r_delay cycles following the AR handshake.
  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      s_aw_got <= 1'b0; s_w_got <= 1'b0; b_busy <= 1'b0; bvalid_r <= 1'b0;
      r_busy <= 1'b0; rvalid_r <= 1'b0; rdata_r <= '0;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      if (aw_hs) aw_cnt <= 0; else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs)  w_cnt  <= 0; else if (wvalid)  w_cnt  <= w_cnt + 1;
      if (ar_hs) ar_cnt <= 0; else if (arvalid) ar_cnt <= ar_cnt + 1;

      if (!b_busy) begin
        if (have_aw && have_w) begin
          for (int i = 0; i < SW; i++)
            if (cur_strb[i]) regs[cur_addr[3:2]][8*i +: 8] <= cur_data[8*i +: 8];
          s_aw_got <= 1'b0;
          s_w_got  <= 1'b0;
          b_busy   <= 1'b1;
          b_cnt    <= 0;
          bvalid_r <= (b_delay == 0);
        end else begin
          if (aw_hs) begin s_aw_got <= 1'b1; s_awaddr <= awaddr; end
          if (w_hs)  begin s_w_got <= 1'b1; s_wdata <= wdata; s_wstrb <= wstrb; end
        end
      end else if (!bvalid_r) begin
        b_cnt <= b_cnt + 1;
        if (b_cnt + 1 >= b_delay) bvalid_r <= 1'b1;
      end else if (bready) begin
        bvalid_r <= 1'b0;
        b_busy   <= 1'b0;
      end

      if (!r_busy) begin
        if (ar_hs) begin
          r_busy   <= 1'b1;
          r_cnt    <= 0;
          rvalid_r <= (r_delay == 0);
          rdata_r  <= rdata_ovr ? rdata_cfg : regs[araddr[3:2]];
        end
      end else if (!rvalid_r) begin
        r_cnt <= r_cnt + 1;
        if (r_cnt + 1 >= r_delay) rvalid_r <= 1'b1;
      end else if (rready) begin
        rvalid_r <= 1'b0;
        r_busy   <= 1'b0;
      end
    end
  end

  // Passive monitor: cycle stamps of handshakes and protocol counters.
  // During cycle k the variable cyc equals k.
  int cyc = 0;
  int acc_count = 0, last_acc_cyc = 0;
  int rsp_count = 0, last_rsp_cyc = 0;
  int last_aw_cyc = 0, last_w_cyc = 0, last_ar_cyc = 0, last_r_cyc = 0;
  int b_count = 0, aw_only_cnt = 0, w_only_cnt = 0, overlap_cnt = 0;
  int proto_err_cnt = 0, rready_gap = 0;
  bit aw_hold = 0, w_hold = 0, ar_hold = 0;
  bit aw_hs_prev = 0, w_hs_prev = 0, ar_hs_prev = 0, r_wait = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin acc_count <= acc_count + 1; last_acc_cyc <= cyc; end
    if (rsp_valid) begin rsp_count <= rsp_count + 1; last_rsp_cyc <= cyc; end
    if (aw_hs) last_aw_cyc <= cyc;
    if (w_hs)  last_w_cyc  <= cyc;
    if (ar_hs) last_ar_cyc <= cyc;
    if (rvalid && rready) last_r_cyc <= cyc;
    if (bvalid && bready) b_count <= b_count + 1;
    if (awvalid && !wvalid) aw_only_cnt <= aw_only_cnt + 1;
    if (wvalid && !awvalid) w_only_cnt <= w_only_cnt + 1;
    if (arvalid && (awvalid || wvalid)) overlap_cnt <= overlap_cnt + 1;
    if ((aw_hold && !awvalid) || (w_hold && !wvalid) || (ar_hold && !arvalid) ||
        (aw_hs_prev && awvalid) || (w_hs_prev && wvalid) || (ar_hs_prev && arvalid))
      proto_err_cnt <= proto_err_cnt + 1;
    aw_hold    <= awvalid && !awready && !rst;
    w_hold     <= wvalid && !wready && !rst;
    ar_hold    <= arvalid && !arready && !rst;
    aw_hs_prev <= aw_hs && !rst;
    w_hs_prev  <= w_hs && !rst;
    ar_hs_prev <= ar_hs && !rst;
    if (rst) r_wait <= 1'b0;
    else if (ar_hs) r_wait <= 1'b1;
    else if (rvalid && rready) r_wait <= 1'b0;
    if (r_wait && !rready) rready_gap <= rready_gap + 1;
  end

  // Presents one command from a negedge and holds it until accepted.
  task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output bit ok);
    int n0;
    n0 = acc_count;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_count != n0) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
  endtask

  // Waits for rsp_valid at a negedge; reports the cycle it was seen in.
  task automatic wait_rsp(output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin ok = 1'b1; at = cyc; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_valids: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready});
    end
    checks++;
    if ({rsp_valid, rsp_write, rsp_rdata, rsp_resp} !== 36'd0) begin
      errors++; $display("[TB] FAIL reset_rsp: got %h expected 0", {rsp_valid, rsp_write, rsp_rdata, rsp_resp});
    end
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_idle: busy=%b cmd_ready=%b expected busy=0 cmd_ready=1", busy, cmd_ready);
    end
    checks++;
    if ({awaddr, araddr, wdata, wstrb, awprot, arprot} !== 50'd0) begin
      errors++; $display("[TB] FAIL reset_regs: got %h expected 0", {awaddr, araddr, wdata, wstrb, awprot, arprot});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_zero_wait();
    bit ok; int at;
    send_cmd(1'b1, 4'h0, 32'h0000_0001, 4'hF, ok);
    wait_rsp(ok, at);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL wr0_timeout: got no rsp_valid expected one"); end
    checks++;
    if (at - last_acc_cyc != 3) begin
      errors++; $display("[TB] FAIL wr0_rsp_latency: got %0d expected 3", at - last_acc_cyc);
    end
    checks++;
    if (last_aw_cyc - last_acc_cyc != 1 || last_w_cyc - last_acc_cyc != 1) begin
      errors++; $display("[TB] FAIL wr0_aw_w_latency: got aw=%0d w=%0d expected 1 1",
                         last_aw_cyc - last_acc_cyc, last_w_cyc - last_acc_cyc);
    end
    checks++;
    if (rsp_write !== 1'b1 || rsp_resp !== 2'b00) begin
      errors++; $display("[TB] FAIL wr0_fields: got write=%b resp=%b expected 1 00", rsp_write, rsp_resp);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr0_pulse: got rsp_valid=%b expected 0", rsp_valid); end

    send_cmd(1'b0, 4'h0, 32'h0, 4'h0, ok);
    wait_rsp(ok, at);
    checks++;
    if (!ok || at - last_acc_cyc != 3 || last_ar_cyc - last_acc_cyc != 1 || last_r_cyc - last_acc_cyc != 2) begin
      errors++; $display("[TB] FAIL rd0_latency: got ok=%b rsp=%0d ar=%0d r=%0d expected 1 3 1 2", ok,
                         at - last_acc_cyc, last_ar_cyc - last_acc_cyc, last_r_cyc - last_acc_cyc);
    end
    checks++;
    if (rsp_rdata !== 32'h0000_0001 || rsp_write !== 1'b0) begin
      errors++; $display("[TB] FAIL rd0_readback: got %h write=%b expected 00000001 0", rsp_rdata, rsp_write);
    end
    @(negedge clk);
  endtask

  task automatic test_write_skew();
    int aw_d [4]  = '{0, 3, 0, 2};
    int w_d  [4]  = '{3, 0, 0, 2};
    int e_aw [4]  = '{1, 4, 1, 3};
    int e_w  [4]  = '{4, 1, 1, 3};
    int e_awo[4]  = '{0, 3, 0, 0};
    int e_wo [4]  = '{3, 0, 0, 0};
    bit ok; int at; int b0, awo0, wo0, pe0;
    for (int k = 0; k < 4; k++) begin
      aw_delay = aw_d[k];
      w_delay  = w_d[k];
      b0 = b_count; awo0 = aw_only_cnt; wo0 = w_only_cnt; pe0 = proto_err_cnt;
      send_cmd(1'b1, 4'h4, 32'h0000_0003, 4'hF, ok);
      wait_rsp(ok, at);
      @(negedge clk);
      checks++;
      if (!ok || at - last_acc_cyc != e_w[k] + 2 + (e_aw[k] > e_w[k] ? e_aw[k] - e_w[k] : 0)) begin
        errors++; $display("[TB] FAIL skew%0d_rsp_latency: got ok=%b lat=%0d expected %0d", k, ok,
                           at - last_acc_cyc, (e_aw[k] > e_w[k] ? e_aw[k] : e_w[k]) + 2);
      end
      checks++;
      if (last_aw_cyc - last_acc_cyc != e_aw[k] || last_w_cyc - last_acc_cyc != e_w[k]) begin
        errors++; $display("[TB] FAIL skew%0d_hs_cycles: got aw=%0d w=%0d expected %0d %0d", k,
                           last_aw_cyc - last_acc_cyc, last_w_cyc - last_acc_cyc, e_aw[k], e_w[k]);
      end
      checks++;
      if (aw_only_cnt - awo0 != e_awo[k] || w_only_cnt - wo0 != e_wo[k]) begin
        errors++; $display("[TB] FAIL skew%0d_split: got aw_only=%0d w_only=%0d expected %0d %0d", k,
                           aw_only_cnt - awo0, w_only_cnt - wo0, e_awo[k], e_wo[k]);
      end
      checks++;
      if (b_count - b0 != 1 || proto_err_cnt != pe0) begin
        errors++; $display("[TB] FAIL skew%0d_b_once: got b=%0d proto_errs=%0d expected 1 0", k,
                           b_count - b0, proto_err_cnt - pe0);
      end
    end
    aw_delay = 0;
    w_delay  = 0;
  endtask

  task automatic test_read_delayed();
    bit ok; int at; int g0;
    r_delay = 5; rdata_ovr = 1'b1; rdata_cfg = 32'hDEAD_BEEF;
    g0 = rready_gap;
    send_cmd(1'b0, 4'h8, 32'h0, 4'h0, ok);
    wait_rsp(ok, at);
    checks++;
    if (!ok || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00 || rsp_write !== 1'b0) begin
      errors++; $display("[TB] FAIL rd_delay_fields: got ok=%b data=%h resp=%b write=%b expected 1 deadbeef 00 0",
                         ok, rsp_rdata, rsp_resp, rsp_write);
    end
    checks++;
    if (last_r_cyc - last_ar_cyc != 6 || rready_gap != g0) begin
      errors++; $display("[TB] FAIL rd_delay_rready: got r-ar=%0d gaps=%0d expected 6 0",
                         last_r_cyc - last_ar_cyc, rready_gap - g0);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_delay_pulse: got rsp_valid=%b expected 0", rsp_valid); end
    r_delay = 0; rdata_ovr = 1'b0;
  endtask

  task automatic test_error_passthrough();
    bit ok; int at;
    bresp_cfg = 2'b10;
    send_cmd(1'b1, 4'hC, 32'h0000_0055, 4'hF, ok);
    wait_rsp(ok, at);
    checks++;
    if (!ok || rsp_resp !== 2'b10 || rsp_write !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++; $display("[TB] FAIL err_fields: got ok=%b resp=%b write=%b data=%h expected 1 10 1 00000000",
                         ok, rsp_resp, rsp_write, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_resp !== 2'b10) begin
      errors++; $display("[TB] FAIL err_idle: got ready=%b busy=%b rsp_valid=%b resp=%b expected 1 0 0 10",
                         cmd_ready, busy, rsp_valid, rsp_resp);
    end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_back_to_back();
    bit ok; int at; int n0, r0, ov0, rsp1, acc2;
    n0 = acc_count; r0 = rsp_count; ov0 = overlap_cnt;
    ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'hA5A5_0F0F; cmd_wstrb = 4'b0101;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_count != n0) begin ok = 1'b1; break; end
    end
    cmd_write = 1'b0; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'h0;
    checks++;
    if (!ok || cmd_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_first: got ok=%b cmd_ready=%b expected 1 0", ok, cmd_ready);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (acc_count == n0 + 2) begin ok = 1'b1; break; end
    end
    cmd_valid = 1'b0;
    rsp1 = last_rsp_cyc;
    acc2 = last_acc_cyc;
    checks++;
    if (!ok || rsp_count - r0 != 1 || acc2 != rsp1 + 1) begin
      errors++; $display("[TB] FAIL b2b_second_accept: got ok=%b rsps=%0d accept-rsp=%0d expected 1 1 1",
                         ok, rsp_count - r0, acc2 - rsp1);
    end
    wait_rsp(ok, at);
    checks++;
    if (!ok || rsp_rdata !== 32'h00A5_000F || rsp_write !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_readback: got ok=%b data=%h write=%b expected 1 00a5000f 0",
                         ok, rsp_rdata, rsp_write);
    end
    checks++;
    if (overlap_cnt != ov0) begin
      errors++; $display("[TB] FAIL b2b_overlap: got %0d overlapping cycles expected 0", overlap_cnt - ov0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok; int at;
    aw_delay = 20;
    send_cmd(1'b1, 4'h4, 32'h0000_0007, 4'hF, ok);
    checks++;
    if (!ok || awvalid !== 1'b1 || awready !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_setup: got ok=%b awvalid=%b awready=%b expected 1 1 0", ok, awvalid, awready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({awvalid, wvalid, bready, arvalid, rready, busy, rsp_valid} !== 7'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_mid_outputs: got %b ready=%b expected 0000000 1",
                         {awvalid, wvalid, bready, arvalid, rready, busy, rsp_valid}, cmd_ready);
    end
    checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== 35'd0) begin
      errors++; $display("[TB] FAIL rst_mid_rsp: got %h expected 0", {rsp_write, rsp_rdata, rsp_resp});
    end
    rst = 1'b0;
    aw_delay = 0;
    @(negedge clk);
    send_cmd(1'b1, 4'h4, 32'h1234_5678, 4'hF, ok);
    wait_rsp(ok, at);
    checks++;
    if (!ok || at - last_acc_cyc != 3 || rsp_resp !== 2'b00) begin
      errors++; $display("[TB] FAIL rst_mid_write: got ok=%b lat=%0d resp=%b expected 1 3 00", ok, at - last_acc_cyc, rsp_resp);
    end
    @(negedge clk);
    send_cmd(1'b0, 4'h4, 32'h0, 4'h0, ok);
    wait_rsp(ok, at);
    checks++;
    if (!ok || at - last_acc_cyc != 3 || rsp_rdata !== 32'h1234_5678 || rsp_write !== 1'b0) begin
      errors++; $display("[TB] FAIL rst_mid_read: got ok=%b lat=%0d data=%h write=%b expected 1 3 12345678 0",
                         ok, at - last_acc_cyc, rsp_rdata, rsp_write);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    $display("[TB] starting axi_lite_master tests");
    test_reset();
    test_write_zero_wait();
    test_write_skew();
    test_read_delayed();
    test_error_passthrough();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
